// File: rtl/fetch_unit.sv
// fetch_unit: PC generation and instruction fetch front end feeding the IF/ID
// register. Issues sequential word fetches over a valid/ready request channel,
// buffers in-order responses in a small FIFO, and flushes on EX redirects while
// discarding responses still in flight from the old path.
// Optional macro FETCH_PERF_CNT_EN adds a saturating starvation counter on
// perf_starve_count; without it the port is tied to zero.
module fetch_unit #(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     FIFO_DEPTH      = 2,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            pause,
    output logic            inst_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     inst_out,
    output logic [31:0]     perf_starve_count
);

    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    // Address of the next response that will be kept; advances only on kept
    // responses, so it always tracks the new path after a redirect.
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]     fifo_inst_q [FIFO_DEPTH];

    logic            credit_ok;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_tgt;
    logic            unused_redirect_lsb;

    assign redirect_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Outstanding requests (including ones that will be dropped) hold FIFO
    // credit, which is what keeps the FIFO from ever overflowing.
    assign credit_ok = (32'(outst_q) < 32'(MAX_OUTSTANDING)) &&
                       ((32'(outst_q) + 32'(count_q)) < 32'(FIFO_DEPTH));

    assign imem_req_valid = ~reset & ~redirect_valid & credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign push       = imem_rsp_valid & (drop_q == '0) & ~redirect_valid;
    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid & ~pause & ~redirect_valid;

    assign pc_out   = inst_valid ? fifo_pc_q[rd_ptr_q]   : '0;
    assign inst_out = inst_valid ? fifo_inst_q[rd_ptr_q] : NOP;

    // Next-state for pc, credit counters and FIFO pointers; redirect wins.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q + OW'(req_fire) - OW'(imem_rsp_valid);
        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            drop_d     = outst_q - OW'(imem_rsp_valid);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - OW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; validity is tracked by count_q so no reset is needed.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
            fifo_inst_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] starve_q;

    // Count cycles where the decoder could accept but nothing is buffered.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= '0;
        end else if (~pause & ~inst_valid & ~redirect_valid & (starve_q != '1)) begin
            starve_q <= starve_q + 32'd1;
        end
    end

    assign perf_starve_count = starve_q;
`else
    assign perf_starve_count = '0;
`endif

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(imem_rsp_valid && (drop_q == '0) && (count_q == CW'(FIFO_DEPTH))));

    a_drop_le_outst: assert property (@(posedge clock) disable iff (reset)
        drop_q <= outst_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: behavioural instruction memory (in-order, one
// cycle minimum latency, responses can be held back) plus a scoreboard of
// expected pc values in delivery order.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        pause;
    logic        inst_valid;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic [31:0] perf_starve_count;

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock             (clock),
        .reset             (reset),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rsp_data     (imem_rsp_data),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .pause             (pause),
        .inst_valid        (inst_valid),
        .pc_out            (pc_out),
        .inst_out          (inst_out),
        .perf_starve_count (perf_starve_count)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_q [$];
    logic [31:0] sb_q  [$];
    logic [31:0] exp_addr;
    int          tb_out;
    logic [31:0] starve;
    logic        rsp_en;
    logic        last_req_valid;
    logic        last_inst_valid;
    logic        cap_first;
    logic [31:0] first_addr;
    logic [31:0] prev_hs_addr;
    logic [31:0] wrap_addr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h00C0_FFEE;
    endfunction

    function automatic logic [31:0] exp_perf();
`ifdef FETCH_PERF_CNT_EN
        return starve;
`else
        return 32'd0;
`endif
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        logic hs;
        if (!reset && rsp_en && mem_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        last_req_valid  = imem_req_valid;
        last_inst_valid = inst_valid;
        if (reset) begin
            check_val("rst_req_valid", imem_req_valid, 0);
            check_val("rst_inst_valid", inst_valid, 0);
            mem_q.delete();
            sb_q.delete();
            exp_addr = 32'h0;
            tb_out   = 0;
            starve   = 32'h0;
        end else begin
            check_val("perf", perf_starve_count, exp_perf());
            if (inst_valid) begin
                check_val("head_present", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    check_val("head_pc", pc_out, sb_q[0]);
                    check_val("head_inst", inst_out, inst_of(sb_q[0]));
                end
            end else begin
                check_val("empty_pc", pc_out, 0);
                check_val("empty_inst", inst_out, NOP);
            end
            if (redirect_valid) check_val("redir_req_valid", imem_req_valid, 0);
            if (imem_req_valid) check_val("credit", tb_out < 2, 1);
            hs = imem_req_valid && imem_req_ready;
            if (hs) begin
                check_val("req_addr", imem_req_addr, exp_addr);
                sb_q.push_back(exp_addr);
                mem_q.push_back(imem_req_addr);
                exp_addr = exp_addr + 32'd4;
                if (cap_first) begin
                    first_addr = imem_req_addr;
                    cap_first  = 1'b0;
                end
                if (prev_hs_addr == 32'hFFFF_FFFC) wrap_addr = imem_req_addr;
                prev_hs_addr = imem_req_addr;
            end
            if (inst_valid && !pause && !redirect_valid && sb_q.size() > 0)
                void'(sb_q.pop_front());
            if (redirect_valid) begin
                sb_q.delete();
                exp_addr = {redirect_pc[31:2], 2'b00};
            end
            tb_out = tb_out + int'(hs) - int'(imem_rsp_valid);
            if (!pause && !inst_valid && !redirect_valid && starve != 32'hFFFF_FFFF)
                starve = starve + 32'd1;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run(input int n, input logic rdy, input logic pse, input logic en);
        redirect_valid = 1'b0;
        imem_req_ready = rdy;
        pause          = pse;
        rsp_en         = en;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect_to(input logic [31:0] tgt, input logic rdy, input logic en);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        imem_req_ready = rdy;
        pause          = 1'b0;
        rsp_en         = en;
        cap_first      = 1'b1;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((tb_out != 0 || sb_q.size() != 0) && n < 30) begin
            run(1, 1'b0, 1'b0, 1'b1);
            n++;
        end
        check_val("drain_left", sb_q.size(), 0);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
        int n = 0;
        while (!inst_valid && n < 12) begin
            run(1, 1'b1, 1'b0, 1'b1);
            n++;
        end
        check_val(tag, pc_out, exp_pc);
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        pause          = 1'b0;
        rsp_en         = 1'b1;
        cap_first      = 1'b0;
        first_addr     = '0;
        prev_hs_addr   = '0;
        wrap_addr      = 32'hDEAD_BEEF;
        @(negedge clock);
        run(3, 1'b1, 1'b0, 1'b1);
        check_val("rst_pc_out", pc_out, 0);
        check_val("rst_inst_out", inst_out, NOP);

        // Streaming after reset release: first instruction two edges later.
        reset = 1'b0;
        check_val("iv_c0", inst_valid, 0);
        run(1, 1'b1, 1'b0, 1'b1);
        check_val("iv_c1", inst_valid, 0);
        run(1, 1'b1, 1'b0, 1'b1);
        check_val("iv_c2", inst_valid, 1);
        check_val("first_pc", pc_out, 32'h0);
        run(8, 1'b1, 1'b0, 1'b1);

        // Pause with the buffer filling: requests must stop, head must hold.
        run(5, 1'b1, 1'b1, 1'b1);
        check_val("pause_req_stop", last_req_valid, 0);
        check_val("pause_head_valid", last_inst_valid, 1);
        run(8, 1'b1, 1'b0, 1'b1);

        // Redirect with two old-path requests still outstanding.
        drain();
        redirect_to(32'h10, 1'b0, 1'b1);
        run(3, 1'b1, 1'b0, 1'b0);
        check_val("two_outstanding", tb_out, 2);
        redirect_to(32'h103, 1'b1, 1'b0);
        run(1, 1'b1, 1'b0, 1'b1);
        check_val("dropped_empty", inst_valid, 0);
        wait_valid("redir_first_pc", 32'h100);
        check_val("redir_first_addr", first_addr, 32'h100);
        run(4, 1'b1, 1'b0, 1'b1);

        // Redirect coinciding with a response and a stalled request.
        drain();
        redirect_to(32'h200, 1'b0, 1'b1);
        run(1, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0);
        check_val("stall_req_valid", last_req_valid, 1);
        redirect_to(32'h302, 1'b0, 1'b1);
        wait_valid("redir2_first_pc", 32'h300);
        check_val("redir2_first_addr", first_addr, 32'h300);
        run(4, 1'b1, 1'b0, 1'b1);

        // Fetch address wrap at the top of the address space.
        drain();
        redirect_to(32'hFFFF_FFF8, 1'b1, 1'b1);
        run(8, 1'b1, 1'b0, 1'b1);
        check_val("wrap_addr", wrap_addr, 32'h0);

        // Starvation: memory not ready for ten cycles.
        drain();
        redirect_to(32'h400, 1'b0, 1'b1);
        run(10, 1'b0, 1'b0, 1'b1);
        check_val("starve_count", perf_starve_count, exp_perf());
        run(6, 1'b1, 1'b0, 1'b1);

        // Randomised traffic with variable memory latency and redirects.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                redirect_to($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                run(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) != 0));
            end
        end
        drain();

        // Reset in the middle of traffic forgets everything in flight.
        run(2, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        run(2, 1'b1, 1'b0, 1'b1);
        check_val("rst2_inst_valid", inst_valid, 0);
        reset = 1'b0;
        cap_first = 1'b1;
        wait_valid("rst2_first_pc", 32'h0);
        check_val("rst2_first_addr", first_addr, 32'h0);
        run(6, 1'b1, 1'b0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- PC-generation and instruction-fetch front end; sits directly upstream of the IF/ID pipeline register and feeds it pc/instruction pairs.
- Issues sequential fetch requests to instruction memory over a valid/ready request channel and collects in-order responses into a small instruction FIFO.
- Handles branch/jump redirects from EX by flushing buffered instructions and discarding responses still in flight from the old path.
- Stalls cleanly under the pipeline pause signal.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 0, fetch address after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2.
- MAX_OUTSTANDING, 2, max accepted-but-unanswered imem requests; 1..FIFO_DEPTH.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; in order, one per accepted request, no backpressure.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  single-cycle control-flow redirect from EX.
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored and forced to 0.
- pause  in  1  downstream stall; head entry is held.
- inst_valid  out  1  head entry valid; IF/ID bubble is driven from ~inst_valid.
- pc_out  out  XLEN  pc of head entry.
- inst_out  out  32  instruction at head entry.
- perf_starve_count  out  32  starvation counter (see Optional Feature).

Behaviour:
- Decided interface: single clock `clock`; `reset` is synchronous and active-high.
- Reset values:
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; drop = 0.
  - imem_req_valid = 0 and inst_valid = 0 during the reset cycle.
  - Empty-FIFO outputs apply: pc_out = 0, inst_out = 0x00000013 (NOP).
- Reset asserted mid-transaction: all in-flight responses are forgotten. The memory side is reset by the same signal.
- Outputs are driven from registers or the FIFO head only. There is no combinational path from imem_rsp_* to inst_*.
- Request issue: imem_req_valid = ~reset & ~redirect_valid & (outstanding < MAX_OUTSTANDING) & (outstanding + fifo_count < FIFO_DEPTH).
  - imem_req_addr = fetch_pc.
  - On valid & ready: fetch_pc += 4 (wraps modulo 2^XLEN), outstanding++.
  - While valid & ~ready, addr stays stable unless a redirect arrives. A redirect may drop valid without a handshake; the memory must tolerate this.
- Response:
  - If drop > 0: discard the response, drop--, outstanding--.
  - Else: push {fetch address, imem_rsp_data} into the FIFO, outstanding--.
  - The credit rule guarantees the FIFO never overflows. A response arriving with the FIFO full and drop == 0 is a protocol error; assert it in simulation.
- Response latency: a response captured at edge N is visible on inst_* after edge N (earliest consumption is the cycle after arrival).
- Pop: when inst_valid & ~pause & ~redirect_valid, advance the FIFO head at the clock edge.
- Same-cycle push and pop are allowed at any occupancy; count is unchanged.
- Empty FIFO: inst_valid = 0, pc_out = 0, inst_out = NOP.
- Redirect (redirect_valid = 1) has priority over pop, push and issue:
  - FIFO flushed; fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - drop <= outstanding, minus 1 if a response arrives this cycle. No request is accepted in the redirect cycle, so drop covers exactly the old-path requests.
  - A response arriving in the redirect cycle is discarded and decrements outstanding.
  - First new-path request is issued in the cycle after the redirect.
  - Back-to-back redirects: the later one wins; drop is recomputed from current outstanding.
- Counters: outstanding and drop are each sized clog2(MAX_OUTSTANDING+1) bits, and drop <= outstanding always holds.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - perf_starve_count is a 32-bit register, reset to 0.
  - Increments every cycle with ~reset & ~pause & ~inst_valid & ~redirect_valid.
  - Saturates at 0xFFFFFFFF.
- Undefined: perf_starve_count tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset then always-ready memory with 1-cycle response, pause = 0:
  - imem_req_addr = 0x0, 0x4, 0x8 on consecutive handshakes.
  - inst_valid first high 2 cycles after reset release.
  - pc_out sequence 0x0, 0x4, 0x8 with matching inst_out.
- Hold pause = 1 for 5 cycles with the FIFO filling:
  - Requests stop once outstanding + fifo_count = 2.
  - Head pc/inst stay stable; no entry is lost or duplicated after pause drops.
- Two requests outstanding (0x10, 0x14) when redirect_valid with redirect_pc = 0x103:
  - Both responses discarded; FIFO empty.
  - Next request addr = 0x100; first delivered pc_out = 0x100.
- Redirect in the same cycle as a response and a stalled request (ready = 0):
  - Response dropped; imem_req_valid low that cycle.
  - drop = outstanding - 1; the following fetch starts at the target.
- fetch_pc = 0xFFFFFFFC with XLEN = 32: next request addr = 0x00000000 (wrap).
- FETCH_PERF_CNT_EN defined, memory ready = 0 for 10 cycles, pause = 0:
  - perf_starve_count = 10 (±1 for the pipeline fill cycle, checked exactly against the rule).
  - Undefined build reads 0.
